cmp_result_monitor: RTL and testbench

//  Registered consumer of a magnitude comparator's one-hot result flags (alb/aeb/agb).

---
 rtl/cmp_result_monitor_pkg.sv | 18 +
 rtl/cmp_result_monitor_if.sv | 24 ++
 rtl/cmp_result_monitor_sat_counter.sv | 20 ++
 rtl/cmp_result_monitor.sv | 108 ++++++++++
 tb/tb_cmp_result_monitor.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cmp_result_monitor_pkg.sv
// Shared types for the comparator result monitor: FSM state encoding and
// the sample legality check.
package cmp_result_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ALARM  = 2'd2
  } mon_state_e;

  function automatic logic onehot3(input logic a, input logic b, input logic c);
    case ({a, b, c})
      3'b100, 3'b010, 3'b001: onehot3 = 1'b1;
      default:                onehot3 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// Sample/result bundle between a comparator-side driver and the monitor.
interface cmp_result_monitor_if #(parameter int unsigned CNT_W = 8);
  logic             in_valid;
  logic             alb;
  logic             aeb;
  logic             agb;
  logic             clr_counts;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic             alarm;
  logic             alarm_pulse;
  logic             err;

  modport master (
    output in_valid, alb, aeb, agb, clr_counts,
    input  lt_cnt, eq_cnt, gt_cnt, alarm, alarm_pulse, err
  );

  modport slave (
    input  in_valid, alb, aeb, agb, clr_counts,
    output lt_cnt, eq_cnt, gt_cnt, alarm, alarm_pulse, err
  );
endinterface

// File: rtl/cmp_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// Counts comparator outcomes and raises a hysteretic alarm on sustained a>b.
module cmp_result_monitor
  import cmp_result_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CLR_LEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_monitor_if.slave  mon
);

  localparam int unsigned MAX_LEN = (RUN_LEN > CLR_LEN) ? RUN_LEN : CLR_LEN;
  localparam int unsigned RUN_W   = $clog2(MAX_LEN + 1);

  mon_state_e       state, state_nx;
  logic [RUN_W-1:0] run, run_nx;
  logic             pulse_q;
  logic             err_q;
  logic             legal;
  logic             illegal;
  int unsigned      run_inc;

  assign legal   = mon.in_valid &&  onehot3(mon.alb, mon.aeb, mon.agb);
  assign illegal = mon.in_valid && !onehot3(mon.alb, mon.aeb, mon.agb);
  assign run_inc = 32'(run) + 1;

  sat_counter #(.W(CNT_W)) u_lt (
    .clk(clk), .rst(rst), .clr(mon.clr_counts), .inc(legal && mon.alb), .q(mon.lt_cnt)
  );
  sat_counter #(.W(CNT_W)) u_eq (
    .clk(clk), .rst(rst), .clr(mon.clr_counts), .inc(legal && mon.aeb), .q(mon.eq_cnt)
  );
  sat_counter #(.W(CNT_W)) u_gt (
    .clk(clk), .rst(rst), .clr(mon.clr_counts), .inc(legal && mon.agb), .q(mon.gt_cnt)
  );

  // In ALARM the run counter is reused to count consecutive non-agb samples,
  // so a direct IDLE->ALARM entry (RUN_LEN==1) starts it at zero.
  always_comb begin
    state_nx = state;
    run_nx   = run;
    case (state)
      IDLE: begin
        if (legal && mon.agb) begin
          if (RUN_LEN == 1) begin
            state_nx = ALARM;
            run_nx   = '0;
          end else begin
            state_nx = ARMING;
            run_nx   = RUN_W'(1);
          end
        end
      end
      ARMING: begin
        if (legal && mon.agb) begin
          if (run_inc >= RUN_LEN) begin
            state_nx = ALARM;
            run_nx   = '0;
          end else begin
            run_nx = RUN_W'(run_inc);
          end
        end else if (legal) begin
          state_nx = IDLE;
          run_nx   = '0;
        end
      end
      ALARM: begin
        if (legal && mon.agb) begin
          run_nx = '0;
        end else if (legal) begin
          if (run_inc >= CLR_LEN) begin
            state_nx = IDLE;
            run_nx   = '0;
          end else begin
            run_nx = RUN_W'(run_inc);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        run_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run     <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      run     <= run_nx;
      pulse_q <= (state != ALARM) && (state_nx == ALARM);
      if (illegal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mon.alarm       = (state == ALARM);
  assign mon.alarm_pulse = pulse_q;
  assign mon.err         = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed scenarios plus randomized traffic
// checked against a streak-based reference model; a CNT_W=2 copy covers saturation.
module tb_cmp_result_monitor;

  localparam int unsigned RUN_LEN = 3;
  localparam int unsigned CLR_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cmp_result_monitor_if #(.CNT_W(8)) ifa ();
  cmp_result_monitor_if #(.CNT_W(2)) ifb ();

  cmp_result_monitor #(.CNT_W(8), .RUN_LEN(RUN_LEN), .CLR_LEN(CLR_LEN)) dut (
    .clk(clk), .rst(rst), .mon(ifa.slave)
  );
  cmp_result_monitor #(.CNT_W(2), .RUN_LEN(RUN_LEN), .CLR_LEN(CLR_LEN)) dut_small (
    .clk(clk), .rst(rst), .mon(ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: raw (unbounded) counts, alarm level and the current streak
  int m_lt, m_eq, m_gt;
  bit m_alarm, m_pulse, m_err;
  int m_streak;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_lt = 0; m_eq = 0; m_gt = 0;
    m_alarm = 0; m_pulse = 0; m_err = 0; m_streak = 0;
  endtask

  task automatic model_step(input bit v, input bit l, input bit e, input bit g, input bit c);
    int n;
    n = int'(l) + int'(e) + int'(g);
    m_pulse = 0;
    if (v && n != 1) m_err = 1;
    if (c) begin
      m_lt = 0; m_eq = 0; m_gt = 0;
    end else if (v && n == 1) begin
      if (l) m_lt++;
      if (e) m_eq++;
      if (g) m_gt++;
    end
    if (v && n == 1) begin
      if (!m_alarm) begin
        if (g) begin
          m_streak++;
          if (m_streak >= RUN_LEN) begin
            m_alarm = 1; m_pulse = 1; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else begin
        if (g) begin
          m_streak = 0;
        end else begin
          m_streak++;
          if (m_streak >= CLR_LEN) begin
            m_alarm = 0; m_streak = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".lt"},     int'(ifa.lt_cnt),      sat(m_lt, 8));
    check({ctx, ".eq"},     int'(ifa.eq_cnt),      sat(m_eq, 8));
    check({ctx, ".gt"},     int'(ifa.gt_cnt),      sat(m_gt, 8));
    check({ctx, ".alarm"},  int'(ifa.alarm),       int'(m_alarm));
    check({ctx, ".pulse"},  int'(ifa.alarm_pulse), int'(m_pulse));
    check({ctx, ".err"},    int'(ifa.err),         int'(m_err));
    check({ctx, ".s_lt"},   int'(ifb.lt_cnt),      sat(m_lt, 2));
    check({ctx, ".s_eq"},   int'(ifb.eq_cnt),      sat(m_eq, 2));
    check({ctx, ".s_gt"},   int'(ifb.gt_cnt),      sat(m_gt, 2));
    check({ctx, ".s_alarm"}, int'(ifb.alarm),      int'(m_alarm));
  endtask

  task automatic drive(input bit v, input bit l, input bit e, input bit g, input bit c);
    ifa.in_valid = v; ifa.alb = l; ifa.aeb = e; ifa.agb = g; ifa.clr_counts = c;
    ifb.in_valid = v; ifb.alb = l; ifb.aeb = e; ifb.agb = g; ifb.clr_counts = c;
  endtask

  task automatic step(input string ctx, input bit v, input bit l, input bit e,
                      input bit g, input bit c);
    drive(v, l, e, g, c);
    @(posedge clk);
    model_step(v, l, e, g, c);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx, input int cycles);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all(ctx);
  endtask

  task automatic lt(input string ctx);   step(ctx, 1, 1, 0, 0, 0); endtask
  task automatic eq(input string ctx);   step(ctx, 1, 0, 1, 0, 0); endtask
  task automatic gt(input string ctx);   step(ctx, 1, 0, 0, 1, 0); endtask
  task automatic idle(input string ctx); step(ctx, 0, 1, 1, 1, 0); endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    do_reset("reset", 2);

    lt("cnt"); lt("cnt"); eq("cnt"); gt("cnt"); gt("cnt"); gt("cnt");
    idle("cnt_after");
    lt("hyst"); gt("hyst"); lt("hyst"); eq("hyst");
    idle("hyst_after");

    do_reset("reset2", 1);
    gt("broken"); gt("broken"); eq("broken"); gt("broken");
    do_reset("reset3", 1);
    gt("gap");
    repeat (4) idle("gap");
    gt("gap"); gt("gap");

    step("illegal", 1, 1, 0, 1, 0);
    step("none", 1, 0, 0, 0, 0);
    repeat (5) gt("sat");
    step("clr_gt", 1, 0, 0, 1, 1);
    step("clr_idle", 0, 0, 0, 0, 1);

    do_reset("reset4", 1);
    gt("arm"); gt("arm");
    do_reset("mid_rst", 1);
    gt("after_rst");
    step("err_set", 1, 1, 1, 0, 0);
    do_reset("err_rst", 1);

    for (int i = 0; i < 400; i++) begin
      int r;
      bit v, l, e, g, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        {l, e, g} = 3'($urandom_range(0, 7));
      end else if (r < 11) begin
        {l, e, g} = 3'b001;
      end else if (r < 16) begin
        {l, e, g} = 3'b100;
      end else begin
        {l, e, g} = 3'b010;
      end
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst", 1);
      end else begin
        step("rnd", v, l, e, g, c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
